muldiv_ctrl: RTL
================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have ports, in order: clk in 1 (sole clock, rising edge); resetn in 1 (synchronous, active-low reset).
REQ-002 SHALL have req_valid in 1: pipeline presents an operation this cycle.
REQ-003 SHALL have req_op in 3: operation code. 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 NONE.
REQ-004 SHALL have req_a in 32 and req_b in 32: operands; MTHI/MTLO write req_a.
REQ-005 SHALL have flush in 1: cancels the current and any in-flight operation.
REQ-006 SHALL have outputs busy out 1, stall out 1, hi out 32 and lo out 32 (architectural HI/LO).
REQ-007 SHALL have multiplier ports mul_op out 2, mul_a out 32, mul_b out 32, mul_c in 64 and mul_done in 1.
REQ-008 SHALL have divider ports div_op out 2, div_a out 32, div_b out 32, div_q in 32, div_r in 32 and div_done in 1.
REQ-009 SHALL treat the unit protocol as shared by both units: op 10 = signed start, 01 = unsigned start, 00 = idle; a start is sampled only while done=1; done is low from the cycle after a start until the result is valid; the result is valid while done=1.

Function
REQ-010 SHALL implement states IDLE, MUL_WAIT, DIV_WAIT and DRAIN; busy = (state != IDLE).
REQ-011 SHALL accept a request in a cycle only if req_valid=1, state=IDLE and flush=0; stall = req_valid & busy.
REQ-012 SHALL, on accepted MULT/MULTU, drive mul_op=10/01 combinationally in that cycle (T), with mul_a=req_a and mul_b=req_b, then move to MUL_WAIT.
REQ-013 SHALL, in MUL_WAIT while mul_done=1, write hi=mul_c[63:32] and lo=mul_c[31:0], then move to IDLE.
REQ-014 SHALL make the multiplier result visible on hi/lo from cycle T+6 (4-stage unit done at T+5); busy is high for cycles T+1..T+5.
REQ-015 SHALL, on accepted DIV/DIVU with req_b!=0, drive div_op=10/01 with div_a=req_a and div_b=req_b, then move to DIV_WAIT.
REQ-016 SHALL, in DIV_WAIT while div_done=1, write lo=div_q and hi=div_r, then move to IDLE.
REQ-017 SHALL, on accepted DIV/DIVU with req_b=0, issue nothing, leave hi/lo unchanged and stay in IDLE.
REQ-018 SHALL, on accepted MTHI/MTLO, write hi/lo=req_a at the end of that cycle and stay in IDLE; NONE codes have no effect.
REQ-019 SHALL hold mul_op=00 and div_op=00 in every cycle other than an issue cycle; mul_a/mul_b/div_a/div_b are don't-care when op=00.
REQ-020 SHALL, when flush=1 in MUL_WAIT or DIV_WAIT, move to DRAIN without writing hi/lo, even if done=1 in that cycle.
REQ-021 SHALL, in DRAIN, return to IDLE once the in-flight unit reports done=1, discarding its result; flush has no further effect in DRAIN.
REQ-022 SHALL ignore req_valid in any cycle where flush=1, in every state.
REQ-023 SHALL never start a unit whose done=0; this is guaranteed structurally by states DRAIN/WAIT.

Reset
REQ-024 SHALL, when resetn=0 at a rising edge, set state=IDLE, hi=0 and lo=0, and force mul_op=00 and div_op=00 combinationally while resetn=0.
REQ-025 SHALL, on reset during MUL_WAIT/DIV_WAIT, abandon the operation with no hi/lo write; the units are reset by the same resetn.

Verification
REQ-026 SHALL cover: MULT a=0xFFFFFFFE, b=3 at T -> mul_op=10 at T only; busy T+1..T+5; hi=0xFFFFFFFF, lo=0xFFFFFFFA from T+6.
REQ-027 SHALL cover: MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE; a second req_valid during busy -> stall=1 until IDLE, then it is accepted.
REQ-028 SHALL cover: DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU b=0 -> div_op stays 00 and hi/lo unchanged.
REQ-029 SHALL cover: MULT issued, flush at T+3 -> state DRAIN; at T+5 return to IDLE; hi/lo keep prior values; MTLO 0x1234 in the flush cycle is ignored.
REQ-030 SHALL cover: MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A back-to-back -> hi/lo updated on consecutive edges; resetn=0 mid-MUL_WAIT -> hi=lo=0, busy=0 next cycle.

Source files
------------

// File: rtl/muldiv_ctrl_if.sv
// Bundle between the pipeline, the HI/LO multiply/divide controller and its two
// arithmetic units. The slave modport is the controller's view.
interface muldiv_ctrl_if;
   logic        req_valid;
   logic [2:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        flush;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [1:0]  mul_op;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic [63:0] mul_c;
   logic        mul_done;
   logic [1:0]  div_op;
   logic [31:0] div_a;
   logic [31:0] div_b;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic        div_done;

   modport master (
      output req_valid, req_op, req_a, req_b, flush,
      output mul_c, mul_done, div_q, div_r, div_done,
      input  busy, stall, hi, lo,
      input  mul_op, mul_a, mul_b, div_op, div_a, div_b
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, flush,
      input  mul_c, mul_done, div_q, div_r, div_done,
      output busy, stall, hi, lo,
      output mul_op, mul_a, mul_b, div_op, div_a, div_b
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO controller: issues MULT/DIV to external multi-cycle units, writes their
// results into HI/LO, handles MTHI/MTLO and flushes in-flight operations.
module muldiv_ctrl (
   input  logic         clk,
   input  logic         resetn,
   muldiv_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      OP_NONE  = 3'b000,
      OP_MULT  = 3'b001,
      OP_MULTU = 3'b010,
      OP_DIV   = 3'b011,
      OP_DIVU  = 3'b100,
      OP_MTHI  = 3'b101,
      OP_MTLO  = 3'b110,
      OP_NONE7 = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL_WAIT,
      S_DIV_WAIT,
      S_DRAIN
   } state_e;

   localparam logic [1:0] UNIT_IDLE     = 2'b00;
   localparam logic [1:0] UNIT_UNSIGNED = 2'b01;
   localparam logic [1:0] UNIT_SIGNED   = 2'b10;

   state_e      r_state;
   state_e      w_state_nxt;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [31:0] w_hi_nxt;
   logic [31:0] w_lo_nxt;
   logic        w_accept;
   op_e         w_op;

   assign w_op     = op_e'(bus.req_op);
   assign w_accept = resetn & bus.req_valid & ~bus.flush & (r_state == S_IDLE);

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch can be inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_hi_nxt    = r_hi;
      w_lo_nxt    = r_lo;
      bus.mul_op  = UNIT_IDLE;
      bus.mul_a   = bus.req_a;
      bus.mul_b   = bus.req_b;
      bus.div_op  = UNIT_IDLE;
      bus.div_a   = bus.req_a;
      bus.div_b   = bus.req_b;

      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               unique case (w_op)
                  OP_MULT: begin
                     bus.mul_op  = UNIT_SIGNED;
                     w_state_nxt = S_MUL_WAIT;
                  end
                  OP_MULTU: begin
                     bus.mul_op  = UNIT_UNSIGNED;
                     w_state_nxt = S_MUL_WAIT;
                  end
                  OP_DIV, OP_DIVU: begin
                     // Divide by zero is dropped: nothing issued, HI/LO untouched.
                     if (bus.req_b != 32'd0) begin
                        bus.div_op  = (w_op == OP_DIV) ? UNIT_SIGNED : UNIT_UNSIGNED;
                        w_state_nxt = S_DIV_WAIT;
                     end
                  end
                  OP_MTHI: w_hi_nxt = bus.req_a;
                  OP_MTLO: w_lo_nxt = bus.req_a;
                  default: ;
               endcase
            end
         end
         S_MUL_WAIT: begin
            if (bus.flush) begin
               w_state_nxt = S_DRAIN;
            end else if (bus.mul_done) begin
               w_hi_nxt    = bus.mul_c[63:32];
               w_lo_nxt    = bus.mul_c[31:0];
               w_state_nxt = S_IDLE;
            end
         end
         S_DIV_WAIT: begin
            if (bus.flush) begin
               w_state_nxt = S_DRAIN;
            end else if (bus.div_done) begin
               w_hi_nxt    = bus.div_r;
               w_lo_nxt    = bus.div_q;
               w_state_nxt = S_IDLE;
            end
         end
         S_DRAIN: begin
            // The unit not in flight is idle and already reports done.
            if (bus.mul_done && bus.div_done) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state and HI/LO use non-blocking assignments and a reset sampled on
   // the clock edge, so every flop updates together from pre-edge values.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= S_IDLE;
         r_hi    <= 32'd0;
         r_lo    <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_hi    <= w_hi_nxt;
         r_lo    <= w_lo_nxt;
      end
   end

   assign bus.busy  = (r_state != S_IDLE);
   assign bus.stall = bus.req_valid & bus.busy;
   assign bus.hi    = r_hi;
   assign bus.lo    = r_lo;

endmodule
